// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU output-port serial transmitter: FSM state
// encoding and serial frame geometry.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/cpu_out_uart_tx_byte_fifo.sv
// Byte FIFO between the CPU output port and the serialiser. Pushes into a full
// FIFO and pops from an empty FIFO are ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; occupancy is what defines valid entries.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_out_uart_tx.sv
// Serial transmitter for the CPU output port: buffers written bytes and sends
// them as 8N1 frames, back to back when more data is queued.
module cpu_out_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clkbar,
  input  logic                          resetbar,
  input  logic [7:0]                    out_data,
  input  logic                          out_we,
  output logic                          out_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic          baud_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_head;

  assign baud_last = (baud_cnt == BAUD_LAST);

  // The head is consumed either from idle or on the final stop-bit cycle,
  // which is what makes consecutive frames contiguous.
  assign fifo_pop  = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && baud_last));

  assign out_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clkbar),
    .reset   (resetbar),
    .push    (out_we),
    .pop     (fifo_pop),
    .wr_data (out_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clkbar) begin
    if (resetbar) begin
      overflow <= 1'b0;
    end else if (out_we && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Framing FSM with a registered line driver; the shifter always holds the
  // bit currently on the line in position 0.
  always_ff @(posedge clkbar) begin
    if (resetbar) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!fifo_empty) begin
            shifter <= fifo_head;
            tx      <= 1'b0;
            state   <= START;
          end else begin
            tx <= 1'b1;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shifter[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shifter[1];
              shifter <= shifter >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shifter <= fifo_head;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_out_uart_tx.md
CPU_OUT_UART_TX -- requirements
Module: cpu_out_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 4, clock cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter: FIFO_DEPTH, 4, byte buffer entries (power of two, 2..16).
REQ-003 SHALL have port: clkbar  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: resetbar  input  1  reset, synchronous, active-high (despite the name).
REQ-005 SHALL have port: out_data  input  8  byte written by the CPU output port.
REQ-006 SHALL have port: out_we  input  1  one-cycle write strobe qualifying out_data.
REQ-007 SHALL have port: out_ready  output  1  high when the FIFO can accept a byte (count < FIFO_DEPTH).
REQ-008 SHALL have port: tx  output  1  registered serial line, idle high.
REQ-009 SHALL have port: busy  output  1  high when the FIFO is non-empty or a frame is in progress.
REQ-010 SHALL have port: overflow  output  1  sticky flag for a write dropped because the FIFO was full.
REQ-011 SHALL have port: fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL push out_data on a rising edge where out_we=1 and out_ready=1.
REQ-013 SHALL drop a write with out_we=1 and out_ready=0, leave FIFO contents unchanged, and set overflow on that edge; this applies even if a pop occurs on the same edge.
REQ-014 SHALL leave fifo_count unchanged when a push and a pop occur on the same edge with the FIFO not full.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1; if FIFO non-empty, on the edge: pop head into shift register, tx<=0, go to START.
REQ-017 START: hold tx=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA.
REQ-018 DATA: send 8 bits LSB first, CLKS_PER_BIT cycles each, using a 3-bit bit index, then tx<=1 and go to STOP.
REQ-019 STOP: hold tx=1 for CLKS_PER_BIT cycles; at the end, if FIFO non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
REQ-020 Latency: a byte written at edge E into an empty FIFO while the FSM is IDLE SHALL cause tx to fall at edge E+1.
REQ-021 A full frame SHALL be 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL wrap 7->0.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 On an edge with resetbar=1: FSM<=IDLE, tx<=1, FIFO flushed (fifo_count=0), pointers<=0, overflow<=0, counters<=0.
REQ-026 Derived outputs during and after reset SHALL be out_ready=1 and busy=0.
REQ-027 A reset asserted mid-frame SHALL abort the frame and drive tx=1 at the same edge; the partial byte SHALL be discarded.
REQ-028 Writes on edges with resetbar=1 SHALL be ignored.

Structure
REQ-029 The state enum (IDLE/START/DATA/STOP) and the frame-length constants (8 data bits, 1 start bit, 1 stop bit) SHALL live in the shared package cpu_io_pkg.
REQ-030 The FIFO SHALL be a separate sub-module byte_fifo (push/pop/full/empty/count); the FSM and shifter SHALL be in the top module.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Write 0xA5 once -> tx goes low 1 edge later; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy falls after 40 cycles.
REQ-032 Write 0x01,0x02,0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap; fifo_count peaks at 2.
REQ-033 Write 6 bytes on consecutive cycles from idle -> 5 accepted (1 popped plus 4 buffered), 6th dropped, overflow=1, out_ready=0 while count=4; the 5 accepted bytes are transmitted in order.
REQ-034 Assert reset at cycle 15 of a 0xFF frame -> tx=1 at that edge, fifo_count=0, busy=0, overflow=0; no further frame is sent.
REQ-035 With FIFO at count=4, out_we=1 on the edge of a STOP->START pop -> write dropped, overflow=1, count=3.
REQ-036 Write 0x00 -> tx is low for 36 cycles (start plus 8 data bits) and then high for 4 cycles.
